bnn_weight_streamer: RTL

- Host-side transmitter for the BNN core's weight-loading port.
- Holds a local bank of NUM_NEURONS weight words, written at random from a host write port.
- On `start`, replays the bank as a burst of `load_en` beats in neuron order 0..NUM_NEURONS-1, on the 6-bit weight bus.
- Keeps a mirror of the core's wrapping load pointer so the host can detect misalignment after an abort.

---
 rtl/bnn_weight_streamer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bnn_weight_streamer.sv
// Host-side weight streamer: replays a local bank of weight words as a load_en burst
// to the BNN core and mirrors the core's wrapping load pointer.
module bnn_weight_streamer #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned NUM_WEIGHTS = 6,
  parameter int unsigned GAP         = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_NEURONS)-1:0] wr_addr,
  input  logic [NUM_WEIGHTS-1:0]         wr_data,
  input  logic                           start,
  input  logic                           abort,
  output logic                           load_en,
  output logic [NUM_WEIGHTS-1:0]         weight_out,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_NEURONS)-1:0] ptr,
  output logic                           wr_err
);

  localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
  localparam int unsigned GAP_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [GAP_W-1:0]       gap_cnt;
  logic [NUM_WEIGHTS-1:0] bank [NUM_NEURONS];

  // Power-on weights of the core, repeated every four neurons.
  function automatic logic [NUM_WEIGHTS-1:0] default_word(input int unsigned i);
    logic [NUM_WEIGHTS-1:0] w;
    case (i % 4)
      0:       w = NUM_WEIGHTS'(6'b111000);
      1:       w = NUM_WEIGHTS'(6'b000111);
      2:       w = NUM_WEIGHTS'(6'b001100);
      default: w = NUM_WEIGHTS'(6'b110011);
    endcase
    return w;
  endfunction

  // Outputs lag the state by one edge: each state's action is registered as it is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      load_en    <= 1'b0;
      weight_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ptr        <= '0;
      wr_err     <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        bank[i] <= default_word(i);
      end
    end else begin
      load_en    <= 1'b0;
      weight_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;

      // Bank writes only land while no burst is reading the bank.
      if (wr_en) begin
        if (state == ST_IDLE || state == ST_DONE) begin
          bank[wr_addr] <= wr_data;
        end else begin
          wr_err <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            idx    <= '0;
            wr_err <= 1'b0;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            load_en    <= 1'b1;
            weight_out <= bank[idx];
            ptr        <= ptr + IDX_W'(1);
            busy       <= 1'b1;
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
              if (GAP > 0) begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            busy <= 1'b1;
            if (gap_cnt == GAP_LAST) begin
              state <= ST_SEND;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
